// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state codes, control encodings and opcodes shared by the multi-cycle controller
package mc_ctrl_pkg;
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC     = 4'd2;
  localparam logic [3:0] S_WB_ALU   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_WB_MEM   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_TRAP     = 4'd15;
  localparam logic [4:0] ALUOp_NOP   = 5'b00000;
  localparam logic [4:0] ALUOp_AUIPC = 5'b00010;
  localparam logic [4:0] ALUOp_ADD   = 5'b00011;
  localparam logic [4:0] ALUOp_SUB   = 5'b00100;
  localparam logic [4:0] ALUOp_SLL   = 5'b01000;
  localparam logic [4:0] ALUOp_SRL   = 5'b01100;
  localparam logic [4:0] ALUOp_SRA   = 5'b11000;
  localparam logic [2:0] EXT_CTRL_NONE = 3'b000;
  localparam logic [2:0] EXT_CTRL_S    = 3'b001;
  localparam logic [2:0] EXT_CTRL_I    = 3'b010;
  localparam logic [2:0] EXT_CTRL_U    = 3'b011;
  localparam logic [2:0] EXT_CTRL_B    = 3'b100;
  localparam logic [2:0] dm_word  = 3'b000;
  localparam logic [2:0] dm_half  = 3'b001;
  localparam logic [2:0] dm_halfu = 3'b010;
  localparam logic [2:0] dm_byte  = 3'b011;
  localparam logic [2:0] dm_byteu = 3'b100;
  localparam logic [2:0] NPCOp_PLUS4  = 3'b000;
  localparam logic [2:0] NPCOp_BRANCH = 3'b001;
  localparam logic [1:0] WDSel_ALU = 2'b00;
  localparam logic [1:0] WDSel_MEM = 2'b01;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  typedef enum logic [2:0] {CL_NONE, CL_R, CL_I, CL_AUIPC, CL_LOAD, CL_STORE, CL_BEQ, CL_BNE} cls_t;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier; anything outside the supported set is illegal with zeroed controls
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output cls_t       cls,
  output logic [4:0] alu_op,
  output logic [2:0] ext_op,
  output logic [2:0] dm_type,
  output logic       illegal
);
  logic       f7z, f7s, ld_ok, st_ok;
  logic [4:0] sh_alu;
  logic [2:0] w_dm;
  always_comb begin
    f7z = funct7 == 7'b0000000;
    f7s = funct7 == 7'b0100000;
    sh_alu = funct3 == 3'b001 && f7z ? ALUOp_SLL :
             funct3 == 3'b101 && f7z ? ALUOp_SRL :
             funct3 == 3'b101 && f7s ? ALUOp_SRA : ALUOp_NOP;
    w_dm = funct3 == 3'b000 ? dm_byte : funct3 == 3'b001 ? dm_half :
           funct3 == 3'b010 ? dm_word : funct3 == 3'b100 ? dm_byteu : dm_halfu;
    ld_ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_ok = funct3 inside {3'b000, 3'b001, 3'b010};
    cls = CL_NONE;
    alu_op = ALUOp_NOP;
    ext_op = EXT_CTRL_NONE;
    dm_type = dm_word;
    case (op)
      OP_R: begin
        alu_op = funct3 == 3'b000 ? (f7z ? ALUOp_ADD : f7s ? ALUOp_SUB : ALUOp_NOP) : sh_alu;
        cls = alu_op != ALUOp_NOP ? CL_R : CL_NONE;
      end
      OP_I: begin
        alu_op = funct3 == 3'b000 ? ALUOp_ADD : sh_alu;
        ext_op = EXT_CTRL_I;
        cls = alu_op != ALUOp_NOP ? CL_I : CL_NONE;
      end
      OP_AUIPC: begin
        alu_op = ALUOp_AUIPC;
        ext_op = EXT_CTRL_U;
        cls = CL_AUIPC;
      end
      OP_LOAD: begin
        alu_op = ALUOp_ADD;
        ext_op = EXT_CTRL_I;
        dm_type = w_dm;
        cls = ld_ok ? CL_LOAD : CL_NONE;
      end
      OP_STORE: begin
        alu_op = ALUOp_ADD;
        ext_op = EXT_CTRL_S;
        dm_type = w_dm;
        cls = st_ok ? CL_STORE : CL_NONE;
      end
      OP_BRANCH: begin
        alu_op = ALUOp_SUB;
        ext_op = EXT_CTRL_B;
        cls = funct3 == 3'b000 ? CL_BEQ : funct3 == 3'b001 ? CL_BNE : CL_NONE;
      end
      default: ;
    endcase
    illegal = cls == CL_NONE;
    if (illegal) begin
      alu_op = ALUOp_NOP;
      ext_op = EXT_CTRL_NONE;
      dm_type = dm_word;
    end
  end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle RV32I sequencer; FSM plus handshake timeout, controls latched from mc_decode in DECODE
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int MEM_TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [6:0] Funct7,
  input  logic [2:0] Funct3,
  input  logic       Zero,
  input  logic       i_ready,
  input  logic       d_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic [2:0] EXTOp,
  output logic [4:0] ALUOp,
  output logic [2:0] NPCOp,
  output logic [2:0] DMType,
  output logic [1:0] WDSel,
  output logic       halted,
  output logic [3:0] state_o
);
  localparam int CW = $clog2(MEM_TIMEOUT + 2);
  logic [3:0]    state, nxt;
  logic [CW-1:0] cnt;
  cls_t          cls, cls_r;
  logic [4:0]    alu, alu_r;
  logic [2:0]    ext, ext_r, dm, dm_r;
  logic          ill, ill_r, wait_st, ready, timeout, act;
  mc_decode u_dec (.op(Op), .funct7(Funct7), .funct3(Funct3), .cls(cls), .alu_op(alu),
                   .ext_op(ext), .dm_type(dm), .illegal(ill));
  always_comb begin
    wait_st = state == S_FETCH || state == S_MEM_RD || state == S_MEM_WR;
    ready = state == S_FETCH ? i_ready : d_ready;
    timeout = MEM_TIMEOUT != 0 && wait_st && !ready && cnt == CW'(MEM_TIMEOUT);
    nxt = S_TRAP;
    case (state)
      S_FETCH:    nxt = i_ready ? S_DECODE : S_FETCH;
      S_DECODE:   nxt = ill ? (TRAP_ON_ILLEGAL ? S_TRAP : S_WB_ALU) :
                        cls == CL_LOAD || cls == CL_STORE ? S_MEM_ADDR :
                        cls == CL_BEQ || cls == CL_BNE ? S_BRANCH : S_EXEC;
      S_EXEC:     nxt = S_WB_ALU;
      S_WB_ALU:   nxt = S_FETCH;
      S_MEM_ADDR: nxt = cls_r == CL_LOAD ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   nxt = d_ready ? S_WB_MEM : S_MEM_RD;
      S_WB_MEM:   nxt = S_FETCH;
      S_MEM_WR:   nxt = d_ready ? S_FETCH : S_MEM_WR;
      S_BRANCH:   nxt = S_FETCH;
      default:    nxt = S_TRAP;
    endcase
    if (timeout) nxt = S_TRAP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      cnt <= '0;
      cls_r <= CL_NONE;
      alu_r <= '0;
      ext_r <= '0;
      dm_r <= '0;
      ill_r <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= wait_st && !ready && nxt == state ? cnt + 1'b1 : '0;
      if (state == S_DECODE) begin
        cls_r <= cls;
        alu_r <= alu;
        ext_r <= ext;
        dm_r <= dm;
        ill_r <= ill;
      end
    end
  end
  // latched controls are only presented in the post-decode datapath states
  assign act      = state >= S_EXEC && state <= S_BRANCH;
  assign IRWrite  = state == S_FETCH && i_ready;
  assign PCWrite  = state == S_WB_ALU || state == S_WB_MEM || state == S_BRANCH || (state == S_MEM_WR && d_ready);
  assign RegWrite = (state == S_WB_ALU && !ill_r) || state == S_WB_MEM;
  assign MemRead  = state == S_MEM_RD;
  assign MemWrite = state == S_MEM_WR;
  assign ALUSrc   = state == S_MEM_ADDR || (state == S_EXEC && (cls_r == CL_I || cls_r == CL_AUIPC));
  assign ALUOp    = act ? alu_r : ALUOp_NOP;
  assign EXTOp    = act ? ext_r : EXT_CTRL_NONE;
  assign DMType   = act ? dm_r : dm_word;
  assign NPCOp    = state == S_BRANCH && ((cls_r == CL_BEQ && Zero) || (cls_r == CL_BNE && !Zero)) ? NPCOp_BRANCH : NPCOp_PLUS4;
  assign WDSel    = state == S_WB_MEM ? WDSel_MEM : WDSel_ALU;
  assign halted   = state == S_TRAP;
  assign state_o  = state;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed vector table plus hand sequences for illegal, timeout and reset-abort cases
module tb_mc_ctrl;
  typedef struct packed {
    logic [3:0] st;
    logic [5:0] stb;
    logic [2:0] ext;
    logic [4:0] alu;
    logic [2:0] npc;
    logic [2:0] dm;
    logic [1:0] wd;
    logic       hl;
  } out_t;
  typedef struct packed {
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       z, ir, dr;
    out_t       exp;
  } vec_t;
  localparam logic [6:0] R = 7'b0110011, LD = 7'b0000011, IA = 7'b0010011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, AU = 7'b0010111, BAD = 7'b1111111, F7S = 7'b0100000;
  localparam logic [5:0] NO = 6'b000000, IRW = 6'b010000, WB = 6'b101000, PCW = 6'b100000;
  localparam logic [5:0] RD = 6'b000100, WR = 6'b000010, SRC = 6'b000001, WRD = 6'b100010;
  logic       clk = 1'b0, rst = 1'b1, zero = 1'b0, ir = 1'b0, dr = 1'b0;
  logic [6:0] op = '0, f7 = '0;
  logic [2:0] f3 = '0;
  logic       pcw[3], irw[3], rw[3], mr[3], mw[3], as[3], hl[3];
  logic [2:0] ext[3], npc[3], dm[3];
  logic [4:0] alu[3];
  logic [1:0] wd[3];
  logic [3:0] st[3];
  int         n_cmp = 0, n_fail = 0;
  vec_t       tbl[$];
  always #5 clk = ~clk;
  for (genvar k = 0; k < 3; k++) begin : g_dut
    mc_ctrl #(.TRAP_ON_ILLEGAL(k != 1), .MEM_TIMEOUT(k == 2 ? 4 : 255)) dut (
      .clk(clk), .rst(rst), .Op(op), .Funct7(f7), .Funct3(f3), .Zero(zero),
      .i_ready(ir), .d_ready(dr), .PCWrite(pcw[k]), .IRWrite(irw[k]), .RegWrite(rw[k]),
      .MemRead(mr[k]), .MemWrite(mw[k]), .ALUSrc(as[k]), .EXTOp(ext[k]), .ALUOp(alu[k]),
      .NPCOp(npc[k]), .DMType(dm[k]), .WDSel(wd[k]), .halted(hl[k]), .state_o(st[k]));
  end
  function automatic out_t e(logic [3:0] s, logic [5:0] b, logic [2:0] x = 0, logic [4:0] a = 0,
                             logic [2:0] n = 0, logic [2:0] m = 0, logic [1:0] w = 0, logic h = 0);
    return {s, b, x, a, n, m, w, h};
  endfunction
  function automatic out_t snap(int k);
    return {st[k], pcw[k], irw[k], rw[k], mr[k], mw[k], as[k], ext[k], alu[k], npc[k], dm[k], wd[k], hl[k]};
  endfunction
  task automatic add_v(logic [6:0] o, logic [6:0] f, logic [2:0] t, logic z, logic i, logic d, out_t x);
    tbl.push_back({o, f, t, z, i, d, x});
  endtask
  task automatic check(string nm, int k, out_t x);
    out_t g;
    g = snap(k);
    n_cmp++;
    if (g !== x) begin
      n_fail++;
      $display("FAIL %s dut%0d: got state=%0d stb=%b ext=%b alu=%b npc=%b dm=%b wd=%b halt=%b, want state=%0d stb=%b ext=%b alu=%b npc=%b dm=%b wd=%b halt=%b",
               nm, k, g.st, g.stb, g.ext, g.alu, g.npc, g.dm, g.wd, g.hl, x.st, x.stb, x.ext, x.alu, x.npc, x.dm, x.wd, x.hl);
    end
  endtask
  task automatic drive(logic [6:0] o, logic [6:0] f, logic [2:0] t, logic z, logic i, logic d);
    @(negedge clk);
    rst = 1'b0; op = o; f7 = f; f3 = t; zero = z; ir = i; dr = d;
    #2;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; op = '0; f7 = '0; f3 = '0; zero = 1'b0; ir = 1'b0; dr = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    // add, ready pulses outside FETCH must be ignored
    add_v(R, 0, 0, 0, 1, 0, e(0, IRW));
    add_v(R, 0, 0, 0, 1, 1, e(1, NO));
    add_v(R, 0, 0, 0, 1, 1, e(2, NO, 0, 5'b00011));
    add_v(R, 0, 0, 0, 0, 0, e(3, WB, 0, 5'b00011));
    add_v(R, F7S, 0, 0, 1, 0, e(0, IRW));
    add_v(R, F7S, 0, 0, 0, 0, e(1, NO));
    add_v(R, F7S, 0, 0, 0, 0, e(2, NO, 0, 5'b00100));
    add_v(R, F7S, 0, 0, 0, 0, e(3, WB, 0, 5'b00100));
    // lw with a fetch wait and three data wait states
    add_v(LD, 0, 2, 0, 0, 0, e(0, NO));
    add_v(LD, 0, 2, 0, 1, 0, e(0, IRW));
    add_v(LD, 0, 2, 0, 0, 0, e(1, NO));
    add_v(LD, 0, 2, 0, 0, 1, e(4, SRC, 3'b010, 5'b00011, 0, 3'b000));
    add_v(LD, 0, 2, 0, 0, 0, e(5, RD, 3'b010, 5'b00011, 0, 3'b000));
    add_v(LD, 0, 2, 0, 0, 0, e(5, RD, 3'b010, 5'b00011, 0, 3'b000));
    add_v(LD, 0, 2, 0, 0, 0, e(5, RD, 3'b010, 5'b00011, 0, 3'b000));
    add_v(LD, 0, 2, 0, 0, 1, e(5, RD, 3'b010, 5'b00011, 0, 3'b000));
    add_v(LD, 0, 2, 0, 0, 0, e(6, WB, 3'b010, 5'b00011, 0, 3'b000, 2'b01));
    // sh zero-wait
    add_v(ST, 0, 1, 0, 1, 0, e(0, IRW));
    add_v(ST, 0, 1, 0, 0, 0, e(1, NO));
    add_v(ST, 0, 1, 0, 0, 0, e(4, SRC, 3'b001, 5'b00011, 0, 3'b001));
    add_v(ST, 0, 1, 0, 0, 1, e(7, WRD, 3'b001, 5'b00011, 0, 3'b001));
    // branches
    add_v(BR, 0, 1, 0, 1, 0, e(0, IRW));
    add_v(BR, 0, 1, 0, 0, 0, e(1, NO));
    add_v(BR, 0, 1, 0, 0, 0, e(8, PCW, 3'b100, 5'b00100, 3'b001));
    add_v(BR, 0, 1, 1, 1, 0, e(0, IRW));
    add_v(BR, 0, 1, 1, 0, 0, e(1, NO));
    add_v(BR, 0, 1, 1, 0, 0, e(8, PCW, 3'b100, 5'b00100, 3'b000));
    add_v(BR, 0, 0, 1, 1, 0, e(0, IRW));
    add_v(BR, 0, 0, 1, 0, 0, e(1, NO));
    add_v(BR, 0, 0, 1, 0, 0, e(8, PCW, 3'b100, 5'b00100, 3'b001));
    add_v(BR, 0, 0, 0, 1, 0, e(0, IRW));
    add_v(BR, 0, 0, 0, 0, 0, e(1, NO));
    add_v(BR, 0, 0, 0, 0, 0, e(8, PCW, 3'b100, 5'b00100, 3'b000));
    // srai, slli, srl, auipc
    add_v(IA, F7S, 5, 0, 1, 0, e(0, IRW));
    add_v(IA, F7S, 5, 0, 0, 0, e(1, NO));
    add_v(IA, F7S, 5, 0, 0, 0, e(2, SRC, 3'b010, 5'b11000));
    add_v(IA, F7S, 5, 0, 0, 0, e(3, WB, 3'b010, 5'b11000));
    add_v(IA, 0, 1, 0, 1, 0, e(0, IRW));
    add_v(IA, 0, 1, 0, 0, 0, e(1, NO));
    add_v(IA, 0, 1, 0, 0, 0, e(2, SRC, 3'b010, 5'b01000));
    add_v(IA, 0, 1, 0, 0, 0, e(3, WB, 3'b010, 5'b01000));
    add_v(R, 0, 5, 0, 1, 0, e(0, IRW));
    add_v(R, 0, 5, 0, 0, 0, e(1, NO));
    add_v(R, 0, 5, 0, 0, 0, e(2, NO, 0, 5'b01100));
    add_v(R, 0, 5, 0, 0, 0, e(3, WB, 0, 5'b01100));
    add_v(AU, 0, 3, 0, 1, 0, e(0, IRW));
    add_v(AU, 0, 3, 0, 0, 0, e(1, NO));
    add_v(AU, 0, 3, 0, 0, 0, e(2, SRC, 3'b011, 5'b00010));
    add_v(AU, 0, 3, 0, 0, 0, e(3, WB, 3'b011, 5'b00010));
    // lbu zero-wait, sb with one wait
    add_v(LD, 0, 4, 0, 1, 0, e(0, IRW));
    add_v(LD, 0, 4, 0, 0, 0, e(1, NO));
    add_v(LD, 0, 4, 0, 0, 0, e(4, SRC, 3'b010, 5'b00011, 0, 3'b100));
    add_v(LD, 0, 4, 0, 0, 1, e(5, RD, 3'b010, 5'b00011, 0, 3'b100));
    add_v(LD, 0, 4, 0, 0, 0, e(6, WB, 3'b010, 5'b00011, 0, 3'b100, 2'b01));
    add_v(ST, 0, 0, 0, 1, 0, e(0, IRW));
    add_v(ST, 0, 0, 0, 0, 0, e(1, NO));
    add_v(ST, 0, 0, 0, 0, 0, e(4, SRC, 3'b001, 5'b00011, 0, 3'b011));
    add_v(ST, 0, 0, 0, 0, 0, e(7, WR, 3'b001, 5'b00011, 0, 3'b011));
    add_v(ST, 0, 0, 0, 0, 1, e(7, WRD, 3'b001, 5'b00011, 0, 3'b011));
    add_v(R, 0, 0, 0, 0, 0, e(0, NO));
    do_reset();
    drive(0, 0, 0, 0, 0, 0);
    check("reset", 0, e(0, NO));
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].f7, tbl[i].f3, tbl[i].z, tbl[i].ir, tbl[i].dr);
      check($sformatf("vec%0d", i), 0, tbl[i].exp);
    end
    // illegal opcode: trap on dut0, nop retire on dut1
    do_reset();
    drive(BAD, 0, 0, 0, 1, 0);
    check("ill_fetch", 0, e(0, IRW));
    check("ill_fetch", 1, e(0, IRW));
    drive(BAD, 0, 0, 0, 0, 0);
    check("ill_decode", 1, e(1, NO));
    drive(BAD, 0, 0, 0, 0, 0);
    check("ill_nop_wb", 1, e(3, PCW));
    check("ill_trap", 0, e(15, NO, 0, 0, 0, 0, 0, 1'b1));
    drive(BAD, 0, 0, 0, 0, 0);
    check("ill_nop_back", 1, e(0, NO));
    for (int i = 0; i < 20; i++) begin
      drive(BAD, 0, 0, 0, 1, 1);
      check($sformatf("trap_hold%0d", i), 0, e(15, NO, 0, 0, 0, 0, 0, 1'b1));
    end
    // unsupported funct3 on a valid opcode (slt) is illegal too
    do_reset();
    drive(R, 0, 2, 0, 1, 0);
    drive(R, 0, 2, 0, 0, 0);
    drive(R, 0, 2, 0, 0, 0);
    check("slt_trap", 0, e(15, NO, 0, 0, 0, 0, 0, 1'b1));
    // fetch timeout on the MEM_TIMEOUT=4 instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      check($sformatf("to_wait%0d", i), 2, e(0, NO));
    end
    drive(0, 0, 0, 0, 1, 0);
    check("to_trap", 2, e(15, NO, 0, 0, 0, 0, 0, 1'b1));
    // reset while a store is waiting on d_ready
    do_reset();
    drive(ST, 0, 2, 0, 1, 0);
    check("ab_fetch", 0, e(0, IRW));
    drive(ST, 0, 2, 0, 0, 0);
    drive(ST, 0, 2, 0, 0, 0);
    check("ab_addr", 0, e(4, SRC, 3'b001, 5'b00011));
    drive(ST, 0, 2, 0, 0, 0);
    check("ab_wait", 0, e(7, WR, 3'b001, 5'b00011));
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("ab_rst_cycle", 0, e(7, WR, 3'b001, 5'b00011));
    @(negedge clk);
    #2;
    check("ab_dropped", 0, e(0, NO));
    drive(ST, 0, 2, 0, 0, 0);
    check("ab_idle", 0, e(0, NO));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
